// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the tx fifo and the UART serializer.
// The serializer is the master: it watches the empty flag and head word and issues pops.
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_empty;
    logic [DATA_WIDTH-1:0] i_r_data;
    logic                  o_rd;

    modport master (
        input  i_empty,
        input  i_r_data,
        output o_rd
    );

    modport slave (
        output i_empty,
        output i_r_data,
        input  o_rd
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a fifo: one word per start/data/stop frame, LSB first,
// with baud timing from an internal cycle counter and fully registered outputs.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    fifo_uart_tx_if.master         fifo,
    output logic                   o_tx,
    output logic                   o_busy
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  rd_q, rd_d;
    logic                  busy_q, busy_d;
    logic                  baud_wrap;

    // Wrap at CLKS_PER_BIT-1 explicitly so non-power-of-two bit periods stay exact.
    assign baud_wrap = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = baud_wrap ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        rd_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!fifo.i_empty) begin
                    shift_d = fifo.i_r_data;
                    state_d = S_START;
                    rd_d    = 1'b1;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (baud_wrap) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with the state register.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
        end
    end

    assign o_tx    = tx_q;
    assign o_busy  = busy_q;
    assign fifo.o_rd = rd_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: two serializers (4 and 5 clocks per bit) fed by queue-based fifo models;
// monitors decode frames on the falling clock edge and compare against expected words.
module tb_fifo_uart_tx;
    localparam int DW  = 8;
    localparam int CPA = 4;
    localparam int CPB = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_uart_tx_if #(.DATA_WIDTH(DW)) if_a ();
    fifo_uart_tx_if #(.DATA_WIDTH(DW)) if_b ();
    logic tx_a, busy_a, tx_b, busy_b;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPA)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .fifo(if_a.master), .o_tx(tx_a), .o_busy(busy_a)
    );
    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .fifo(if_b.master), .o_tx(tx_b), .o_busy(busy_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end else begin
            $display("ok   %s: %0d (0x%0h)", name, act, act);
        end
    endtask

    // ---------------- fifo models ----------------
    logic [7:0] fifo_a[$], wr_a[$], exp_a[$];
    logic [7:0] fifo_b[$], wr_b[$], exp_b[$];
    int rd_cnt_a = 0, rd_cnt_b = 0;
    int ne_cyc_a = -1;

    initial begin
        logic was_empty;
        if_a.i_empty  = 1'b1;
        if_a.i_r_data = '0;
        forever begin
            @(negedge clk);
            was_empty = if_a.i_empty;
            if (if_a.o_rd === 1'b1) begin
                rd_cnt_a++;
                if (fifo_a.size() > 0) void'(fifo_a.pop_front());
            end
            while (wr_a.size() > 0) fifo_a.push_back(wr_a.pop_front());
            if_a.i_empty  = (fifo_a.size() == 0);
            if_a.i_r_data = (fifo_a.size() > 0) ? fifo_a[0] : 8'h00;
            if (was_empty && !if_a.i_empty) ne_cyc_a = cyc;
        end
    end

    initial begin
        if_b.i_empty  = 1'b1;
        if_b.i_r_data = '0;
        forever begin
            @(negedge clk);
            if (if_b.o_rd === 1'b1) begin
                rd_cnt_b++;
                if (fifo_b.size() > 0) void'(fifo_b.pop_front());
            end
            while (wr_b.size() > 0) fifo_b.push_back(wr_b.pop_front());
            if_b.i_empty  = (fifo_b.size() == 0);
            if_b.i_r_data = (fifo_b.size() > 0) ? fifo_b[0] : 8'h00;
        end
    end

    // ---------------- monitor A: frame decoder ----------------
    logic samp_a [0:10*CPA-1];
    bit   in_a = 0;
    int   pos_a = 0, busy_run_a = 0, idle_run_a = 0, rd_run_a = 0, frames_a = 0;
    int   gaps_a[$];
    int   start_cyc_a = -1;
    logic prev_busy_a = 1'b0;

    initial begin
        logic [7:0] d;
        int shape_bad;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_a = 0; pos_a = 0; busy_run_a = 0; idle_run_a = 0; rd_run_a = 0;
                prev_busy_a = 1'b0;
            end else begin
                if (if_a.o_rd === 1'b1) rd_run_a++;
                else if (rd_run_a > 0) begin
                    check("rd_a pulse width", rd_run_a, 1);
                    rd_run_a = 0;
                end
                if (busy_a && !prev_busy_a) start_cyc_a = cyc;
                prev_busy_a = busy_a;
                if (busy_a) begin
                    if (busy_run_a == 0 && idle_run_a > 0 && frames_a > 0) gaps_a.push_back(idle_run_a);
                    busy_run_a++;
                    idle_run_a = 0;
                end else begin
                    if (busy_run_a > 0) begin
                        check("busy_a length", busy_run_a, 10*CPA);
                        busy_run_a = 0;
                    end
                    idle_run_a++;
                end
                if (!in_a && busy_a && tx_a === 1'b0) begin
                    in_a = 1; pos_a = 0;
                end
                if (in_a) begin
                    samp_a[pos_a] = tx_a;
                    pos_a++;
                    if (pos_a == 10*CPA) begin
                        in_a = 0;
                        shape_bad = 0;
                        for (int b = 0; b < 10; b++)
                            for (int k = 0; k < CPA; k++)
                                if (samp_a[b*CPA+k] !== samp_a[b*CPA]) shape_bad++;
                        if (samp_a[0] !== 1'b0) shape_bad++;
                        if (samp_a[9*CPA] !== 1'b1) shape_bad++;
                        for (int i = 0; i < DW; i++) d[i] = samp_a[(i+1)*CPA];
                        check("frame_a expected entries", exp_a.size() > 0 ? 1 : 0, 1);
                        if (exp_a.size() > 0) check("frame_a data", int'(d), int'(exp_a.pop_front()));
                        check("frame_a shape errors", shape_bad, 0);
                        frames_a++;
                    end
                end
            end
        end
    end

    // ---------------- monitor B: cycle-exact waveform ----------------
    logic wave_b [0:63];
    int   pos_b = 0, frames_b = 0;

    initial begin
        logic [7:0] e;
        logic eb;
        int mism, bi;
        forever begin
            @(negedge clk);
            if (!rst_n) pos_b = 0;
            else if (busy_b) begin
                if (pos_b < 64) wave_b[pos_b] = tx_b;
                pos_b++;
            end else if (pos_b > 0) begin
                check("frame_b length", pos_b, 10*CPB);
                check("frame_b expected entries", exp_b.size() > 0 ? 1 : 0, 1);
                if (exp_b.size() > 0) begin
                    e = exp_b.pop_front();
                    mism = 0;
                    for (int k = 0; k < 10*CPB && k < 64; k++) begin
                        bi = k / CPB;
                        eb = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : e[bi-1];
                        if (wave_b[k] !== eb) mism++;
                    end
                    check("frame_b waveform errors", mism, 0);
                end
                frames_b++;
                pos_b = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_drain_a(input int budget);
        int n = 0;
        while (n < budget && !(fifo_a.size() == 0 && wr_a.size() == 0 && !busy_a && !in_a)) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL drain_a timeout: waited %0d cycles, limit %0d", n, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_drain_b(input int budget);
        int n = 0;
        while (n < budget && !(fifo_b.size() == 0 && wr_b.size() == 0 && !busy_b && pos_b == 0)) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL drain_b timeout: waited %0d cycles, limit %0d", n, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int errs, base, n;
        rst_n = 1'b0;

        errs = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || if_a.o_rd !== 1'b0 || busy_a !== 1'b0 ||
                tx_b !== 1'b1 || if_b.o_rd !== 1'b0 || busy_b !== 1'b0) errs++;
        end
        check("in-reset output bad cycles", errs, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        errs = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || if_a.o_rd !== 1'b0 || busy_a !== 1'b0) errs++;
        end
        check("idle-empty output bad cycles", errs, 0);

        // 5 clocks per bit: exact 50-cycle frame
        @(posedge clk); #1;
        exp_b.push_back(8'h5A); wr_b.push_back(8'h5A);
        wait_drain_b(1000);
        check("rd_b pulses", rd_cnt_b, 1);
        check("frames_b", frames_b, 1);

        // single word 0xA5
        @(posedge clk); #1;
        base = rd_cnt_a;
        exp_a.push_back(8'hA5); wr_a.push_back(8'hA5);
        wait_drain_a(1000);
        check("rd_a pulses for 0xA5", rd_cnt_a - base, 1);
        check("fifo_a empty after 0xA5", fifo_a.size(), 0);

        // back-to-back words
        @(posedge clk); #1;
        base = rd_cnt_a;
        gaps_a.delete();
        exp_a.push_back(8'h00); exp_a.push_back(8'hFF); exp_a.push_back(8'h3C);
        wr_a.push_back(8'h00);  wr_a.push_back(8'hFF);  wr_a.push_back(8'h3C);
        wait_drain_a(2000);
        check("rd_a pulses for burst", rd_cnt_a - base, 3);
        check("burst gap count", gaps_a.size(), 3);
        if (gaps_a.size() == 3) begin
            check("idle gap frame1-2", gaps_a[1], 1);
            check("idle gap frame2-3", gaps_a[2], 1);
        end

        // asynchronous reset during the third data bit
        @(posedge clk); #1;
        wr_a.push_back(8'h5A);
        n = 0;
        while (!busy_a && n < 100) begin @(negedge clk); n++; end
        check("busy_a seen before reset", busy_a ? 1 : 0, 1);
        repeat (13) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("tx_a high right after async reset", int'(tx_a), 1);
        check("busy_a low right after async reset", int'(busy_a), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        base = rd_cnt_a;
        errs = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) errs++;
        end
        check("post-reset idle bad cycles", errs, 0);
        check("rd_a pulses after reset", rd_cnt_a - base, 0);

        // long empty period, then 0x81
        repeat (100) @(negedge clk);
        @(posedge clk); #1;
        ne_cyc_a = -1;
        start_cyc_a = -1;
        exp_a.push_back(8'h81); wr_a.push_back(8'h81);
        wait_drain_a(1000);
        check("start bit delay after non-empty", start_cyc_a - ne_cyc_a, 1);

        check("unmatched expected frames a", exp_a.size(), 0);
        check("unmatched expected frames b", exp_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global timeout: simulation time exceeded");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- UART serializer that drains the tx fifo: consumes `o_empty`/`o_r_data` from the fifo and drives the fifo's `i_rd`.
- Sits directly downstream of the tx fifo. Produces 8N1-style frames: start bit, DATA_WIDTH data bits LSB first, one stop bit.
- Baud timing comes from an internal clock-cycle counter, so no external tick is needed.
- Pulls one word per frame and idles while the fifo is empty.

Parameters:
- DATA_WIDTH, 8: bits per word and per frame; must match the fifo DATA_WIDTH.
- CLKS_PER_BIT, 868: i_clk cycles per serial bit (100 MHz / 115200). Legal range is ≥ 2.

Ports:
- i_clk  input  1  system clock; all state updates on rising edge.
- i_reset_n  input  1  reset, asynchronous assert, active-low.
- i_empty  input  1  fifo empty flag; wired to fifo `o_empty`.
- i_r_data  input  DATA_WIDTH  fifo head word; wired to fifo `o_r_data`; valid whenever i_empty=0.
- o_rd  output  1  fifo pop strobe; wired to fifo `i_rd`; single-cycle pulse.
- o_tx  output  1  serial line; idle high.
- o_busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (i_reset_n=0, asynchronous):
  - state=IDLE; o_tx=1, o_rd=0, o_busy=0.
  - Baud counter, bit index and shift register all cleared.
  - Reset mid-frame aborts the frame immediately and drives o_tx high. No pop is issued during reset. A word already popped is lost.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- State machine: IDLE, START, DATA, STOP.
- IDLE:
  - o_tx=1.
  - If i_empty=0 at a clock edge: capture i_r_data into the shift register, clear the baud counter, go to START, and set o_rd=1 for the next cycle only.
  - If i_empty=1: stay in IDLE; o_rd stays 0.
- o_rd rule: high for exactly one cycle per frame, the first START cycle. The fifo pops at the end of that cycle. The next capture occurs ≥ (DATA_WIDTH+2)·CLKS_PER_BIT cycles later, so i_empty/i_r_data have settled before then.
- START:
  - o_tx=0 for CLKS_PER_BIT cycles.
  - When the baud counter reaches CLKS_PER_BIT-1: counter→0, bit index→0, go to DATA.
- DATA:
  - o_tx = shift register bit 0.
  - At each counter wrap: shift right by 1 and increment the bit index.
  - After the wrap with bit index = DATA_WIDTH-1, go to STOP.
- STOP:
  - o_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame timing:
  - o_tx falls one cycle after the capture edge.
  - The frame occupies exactly (DATA_WIDTH+2)·CLKS_PER_BIT cycles.
  - Back-to-back words are separated by exactly one IDLE cycle (o_tx=1, o_busy=0) before the next start bit.
- Counter widths:
  - Baud counter width = $clog2(CLKS_PER_BIT); wraps at CLKS_PER_BIT-1, never at a power of two.
  - Bit index width = $clog2(DATA_WIDTH)+1 (no overflow at DATA_WIDTH=8).
- Input handling:
  - i_empty and i_r_data are ignored outside IDLE.
  - A fifo write during a frame has no effect until the next IDLE cycle.
- The fifo full flag is not observed; the producer side is responsible for honouring it.

Test Plan:
- Reset with i_empty=1 for 50 cycles → o_tx=1, o_rd=0, o_busy=0 throughout.
- CLKS_PER_BIT=4, DATA_WIDTH=8; fifo holds 0xA5 → o_rd high for exactly 1 cycle. o_tx sequence, each bit held 4 cycles: 0,1,0,1,0,0,1,0,1,1. o_busy high for exactly 40 cycles. Fifo empty afterwards.
- Write 0x00, 0xFF, 0x3C back-to-back (CLKS_PER_BIT=4) → three frames decoded as 0x00, 0xFF, 0x3C in order. Exactly 1 idle-high cycle between consecutive frames. Exactly 3 o_rd pulses.
- Assert i_reset_n=0 during the DATA state of the 3rd bit → o_tx=1 and o_busy=0 immediately (asynchronous). After release with the fifo empty → no further o_rd, o_tx stays 1.
- Keep the fifo empty for 100 cycles, then write 0x81 → capture on the first edge with i_empty=0. o_tx falls on the following cycle. Frame decodes to 0x81.
- CLKS_PER_BIT=5 (non-power-of-two) → every bit lasts exactly 5 cycles; a frame lasts 50 cycles.
